id_hazard_control: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage MIPS core. It sits beside the instruction-decode stage and watches the ID instruction fields, the ID/EX load flag and the MEM-stage branch outcome. From these it drives PC/IF-ID write enables, ID/EX bubble insertion, and IF/ID–ID/EX–EX/MEM flushes. It also sequences a HALT instruction: fetch stops, older instructions drain, and the core parks.

---
 rtl/id_hazard_control_pkg.sv | 16 +
 rtl/id_hazard_control_if.sv | 31 +++
 rtl/id_hazard_control_sat_counter.sv | 20 ++
 rtl/id_hazard_control.sv | 134 +++++++++++++
 tb/tb_id_hazard_control.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_hazard_control_pkg.sv
// Shared definitions for the ID-stage hazard/sequencing controller:
// FSM state encoding, opcodes the controller decodes, and statistics width.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  localparam logic [5:0] OPC_HALT = 6'b111111;
  localparam logic [5:0] OPC_LW   = 6'b100011;

  localparam int CNT_W = 16;

endpackage

// File: rtl/id_hazard_control_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave): ID/EX observations in, enables/flush/status out.
interface id_hazard_control_if #(
  parameter int W = 5
);

  logic [31:0]                 id_instruction;
  logic                        idex_mem_read;
  logic [W-1:0]                idex_rt;
  logic                        mem_branch_taken;
  logic                        pc_write;
  logic                        ifid_write;
  logic                        idex_bubble;
  logic                        flush;
  logic                        halted;
  logic [hazard_pkg::CNT_W-1:0] stall_count;
  logic [hazard_pkg::CNT_W-1:0] flush_count;

  modport master (
    output id_instruction, idex_mem_read, idex_rt, mem_branch_taken,
    input  pc_write, ifid_write, idex_bubble, flush, halted,
           stall_count, flush_count
  );

  modport slave (
    input  id_instruction, idex_mem_read, idex_rt, mem_branch_taken,
    output pc_write, ifid_write, idex_bubble, flush, halted,
           stall_count, flush_count
  );

endinterface

// File: rtl/id_hazard_control_sat_counter.sv
// 16-bit saturating up-counter used for the optional stall/flush statistics.
module sat_counter
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count enabled events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_hazard_control.sv
// Hazard and sequencing controller beside the ID stage of the 5-stage MIPS
// core: load-use stalls, taken-branch flushes and HALT drain/park.
// Optional statistics counters are built when ID_HAZARD_STALL_STATS_EN is
// defined; otherwise stall_count/flush_count are tied to zero.
module id_hazard_control
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int W            = 5
) (
  input logic               clk,
  input logic               reset,
  id_hazard_control_if.slave bus
);

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  hz_state_t  state;
  hz_state_t  state_next;
  logic [2:0] drain_cnt;
  logic [2:0] drain_cnt_next;

  logic [5:0]   opcode;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         load_use;
  logic         pc_write;
  logic         ifid_write;
  logic         idex_bubble;
  logic         flush;
  logic         stall_cycle;
  logic         unused_instr_bits;

  assign opcode            = bus.id_instruction[31:26];
  assign rs                = W'(bus.id_instruction[25:21]);
  assign rt                = W'(bus.id_instruction[20:16]);
  assign unused_instr_bits = ^bus.id_instruction[15:0];

  // rt is compared regardless of opcode; a false stall is cheaper than a miss.
  assign load_use = bus.idex_mem_read && (bus.idex_rt != '0) &&
                    ((bus.idex_rt == rs) || (bus.idex_rt == rt));

  // State and drain counter register; reset parks the FSM back in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  // Next-state and zero-latency pipeline controls from state and ID inputs.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    idex_bubble    = 1'b0;
    flush          = 1'b0;
    stall_cycle    = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.mem_branch_taken) begin
          flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          stall_cycle = 1'b1;
        end else if (opcode == OPC_HALT) begin
          pc_write       = 1'b0;
          ifid_write     = 1'b0;
          idex_bubble    = 1'b1;
          state_next     = DRAIN;
          drain_cnt_next = '0;
        end
      end
      DRAIN: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        if (bus.mem_branch_taken) begin
          flush          = 1'b1;
          pc_write       = 1'b1;
          state_next     = RUN;
          drain_cnt_next = '0;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_next = HALTED;
        end else begin
          drain_cnt_next = drain_cnt + 3'd1;
        end
      end
      HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: begin
        state_next     = RUN;
        drain_cnt_next = '0;
      end
    endcase
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.idex_bubble = idex_bubble;
  assign bus.flush       = flush;
  assign bus.halted      = (state == HALTED);

`ifdef ID_HAZARD_STALL_STATS_EN
  sat_counter u_stall_count (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_cycle),
    .count (bus.stall_count)
  );

  sat_counter u_flush_count (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (bus.flush_count)
  );
`else
  logic unused_stall_cycle;
  assign unused_stall_cycle = stall_cycle;
  assign bus.stall_count    = '0;
  assign bus.flush_count    = '0;
`endif

endmodule

// File: tb/tb_id_hazard_control.sv
// Directed testbench for id_hazard_control: reset values, load-use stalls,
// branch flushes, HALT drain/park, wrong-path HALT and async reset recovery.
module tb_id_hazard_control;

  localparam int DRAIN_CYCLES = 3;

  // {pc_write, ifid_write, idex_bubble, flush, halted}
  localparam logic [4:0] EXP_IDLE   = 5'b11000;
  localparam logic [4:0] EXP_STALL  = 5'b00100;
  localparam logic [4:0] EXP_HALTED = 5'b00101;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  id_hazard_control_if #(.W(5)) bus ();

  id_hazard_control #(
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .W            (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] make_instr(input logic [5:0] opc, input logic [4:0] rs,
                                             input logic [4:0] rt);
    return {opc, rs, rt, 16'h0020};
  endfunction

  function automatic logic [4:0] outs();
    return {bus.pc_write, bus.ifid_write, bus.idex_bubble, bus.flush, bus.halted};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic mem_read, input logic [4:0] xrt,
                       input logic br);
    bus.id_instruction   = instr;
    bus.idex_mem_read    = mem_read;
    bus.idex_rt          = xrt;
    bus.mem_branch_taken = br;
  endtask

  task automatic drive_idle();
    drive(make_instr(6'd0, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    #1;
    total++;
    if (outs() !== EXP_IDLE) $display("[TB] FAIL reset_outputs_in_reset: got %b expected %b", outs(), EXP_IDLE);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (outs() !== EXP_IDLE) $display("[TB] FAIL reset_outputs_idle: got %b expected %b", outs(), EXP_IDLE);
    else passed++;
    total++;
    if ({bus.stall_count, bus.flush_count} !== 32'h0)
      $display("[TB] FAIL reset_counters: got %h expected %h", {bus.stall_count, bus.flush_count}, 32'h0);
    else passed++;
  endtask

  task automatic test_load_use();
    logic [5:0]  opc    [6] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h00, 6'h00};
    logic [4:0]  rs_v   [6] = '{5'd8, 5'd8, 5'd0, 5'd1, 5'd1, 5'd8};
    logic [4:0]  rt_v   [6] = '{5'd3, 5'd3, 5'd0, 5'd9, 5'd2, 5'd3};
    logic        rd_v   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0]  xrt_v  [6] = '{5'd8, 5'd8, 5'd0, 5'd9, 5'd9, 5'd8};
    logic [4:0]  exp_v  [6] = '{EXP_STALL, EXP_IDLE, EXP_IDLE, EXP_STALL, EXP_IDLE, EXP_IDLE};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(make_instr(opc[i], rs_v[i], rt_v[i]), rd_v[i], xrt_v[i], 1'b0);
      #1;
      total++;
      if (outs() !== exp_v[i])
        $display("[TB] FAIL load_use_vec%0d: got %b expected %b", i, outs(), exp_v[i]);
      else passed++;
    end
    @(negedge clk);
    drive_idle();
`ifdef ID_HAZARD_STALL_STATS_EN
    total++;
    if (bus.stall_count !== 16'd2) $display("[TB] FAIL load_use_stall_count: got %0d expected %0d", bus.stall_count, 2);
    else passed++;
`endif
  endtask

  task automatic test_branch_flush();
    do_reset();
    @(negedge clk);
    drive(make_instr(6'd0, 5'd8, 5'd3), 1'b1, 5'd8, 1'b1);
    #1;
    total++;
    if ({bus.pc_write, bus.idex_bubble, bus.flush, bus.halted} !== 4'b1010)
      $display("[TB] FAIL flush_over_hazard: got %b expected %b",
               {bus.pc_write, bus.idex_bubble, bus.flush, bus.halted}, 4'b1010);
    else passed++;
    @(negedge clk);
    drive_idle();
    #1;
    total++;
    if (outs() !== EXP_IDLE) $display("[TB] FAIL after_flush_idle: got %b expected %b", outs(), EXP_IDLE);
    else passed++;
`ifdef ID_HAZARD_STALL_STATS_EN
    total++;
    if ({bus.flush_count, bus.stall_count} !== {16'd1, 16'd0})
      $display("[TB] FAIL flush_stats: got %h expected %h", {bus.flush_count, bus.stall_count}, {16'd1, 16'd0});
    else passed++;
`endif
  endtask

  task automatic test_halt();
    do_reset();
    @(negedge clk);
    drive(make_instr(6'b111111, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
    #1;
    total++;
    if (outs() !== EXP_STALL) $display("[TB] FAIL halt_in_id: got %b expected %b", outs(), EXP_STALL);
    else passed++;
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      @(negedge clk);
      drive_idle();
      #1;
      total++;
      if (outs() !== EXP_STALL) $display("[TB] FAIL drain_cycle%0d: got %b expected %b", i, outs(), EXP_STALL);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(make_instr(6'd0, 5'd8, 5'd3), i[0], 5'd8, i[1]);
      #1;
      total++;
      if (outs() !== EXP_HALTED) $display("[TB] FAIL halted_hold%0d: got %b expected %b", i, outs(), EXP_HALTED);
      else passed++;
    end
`ifdef ID_HAZARD_STALL_STATS_EN
    total++;
    if ({bus.flush_count, bus.stall_count} !== 32'h0)
      $display("[TB] FAIL halted_stats: got %h expected %h", {bus.flush_count, bus.stall_count}, 32'h0);
    else passed++;
`endif
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    #1;
    total++;
    if (outs() !== EXP_IDLE) $display("[TB] FAIL reset_in_halted: got %b expected %b", outs(), EXP_IDLE);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_wrong_path_halt();
    do_reset();
    @(negedge clk);
    drive(make_instr(6'b111111, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    drive_idle();
    #1;
    total++;
    if (outs() !== EXP_STALL) $display("[TB] FAIL wrong_path_drain1: got %b expected %b", outs(), EXP_STALL);
    else passed++;
    @(negedge clk);
    drive(make_instr(6'd0, 5'd1, 5'd2), 1'b0, 5'd0, 1'b1);
    #1;
    total++;
    if ({bus.pc_write, bus.flush, bus.halted} !== 3'b110)
      $display("[TB] FAIL wrong_path_flush: got %b expected %b", {bus.pc_write, bus.flush, bus.halted}, 3'b110);
    else passed++;
    for (int i = 0; i < DRAIN_CYCLES + 2; i++) begin
      @(negedge clk);
      drive_idle();
      #1;
      total++;
      if (outs() !== EXP_IDLE) $display("[TB] FAIL wrong_path_run%0d: got %b expected %b", i, outs(), EXP_IDLE);
      else passed++;
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    @(negedge clk);
    drive(make_instr(6'b111111, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    #1;
    total++;
    if (outs() !== EXP_IDLE) $display("[TB] FAIL reset_in_drain: got %b expected %b", outs(), EXP_IDLE);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (DRAIN_CYCLES + 2) @(negedge clk);
    #1;
    total++;
    if (outs() !== EXP_IDLE) $display("[TB] FAIL run_after_drain_reset: got %b expected %b", outs(), EXP_IDLE);
    else passed++;
  endtask

  task automatic test_stall_saturation();
`ifdef ID_HAZARD_STALL_STATS_EN
    do_reset();
    @(negedge clk);
    drive(make_instr(6'd0, 5'd8, 5'd3), 1'b1, 5'd8, 1'b0);
    repeat (70000) @(negedge clk);
    #1;
    total++;
    if (bus.stall_count !== 16'hFFFF) $display("[TB] FAIL stall_saturate: got %h expected %h", bus.stall_count, 16'hFFFF);
    else passed++;
    total++;
    if (bus.flush_count !== 16'h0000) $display("[TB] FAIL flush_idle_during_stall: got %h expected %h", bus.flush_count, 16'h0000);
    else passed++;
    drive_idle();
`endif
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    drive_idle();
    test_reset();
    test_load_use();
    test_branch_flush();
    test_halt();
    test_wrong_path_halt();
    test_reset_in_drain();
    test_stall_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
